// File: rtl/robot_navigator_if.sv
// Sensor/command bundle between a navigation controller and its driver.
// The master side presents step pulses and sensor readings and observes the decisions.
interface robot_navigator_if;
  logic        step;
  logic        head;
  logic        left;
  logic        under;
  logic        barrier;
  logic        front;
  logic        turn;
  logic        remove;
  logic [2:0]  state;
  logic        done;
  logic        stuck;
  logic [15:0] move_count;

  modport master (
    output step, head, left, under, barrier,
    input  front, turn, remove, state, done, stuck, move_count
  );

  modport slave (
    input  step, head, left, under, barrier,
    output front, turn, remove, state, done, stuck, move_count
  );
endinterface

// File: rtl/robot_navigator.sv
// Left-hand wall-following navigator: one decision per step pulse, trash removal, goal halt.
// Optional macro NAV_STUCK_DETECT_EN halts in STUCK after 12 consecutive turning steps without progress.
module robot_navigator (
  input  logic               clock,
  input  logic               reset,
  robot_navigator_if.slave   nav
);

  typedef enum logic [2:0] {
    FOLLOW     = 3'd0,
    ADVANCE    = 3'd1,
    RIGHT_TURN = 3'd2,
    REMOVE     = 3'd3,
    DONE       = 3'd4,
    STUCK      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        front_q, front_d;
  logic        turn_q, turn_d;
  logic        remove_q, remove_d;
  logic [1:0]  remaining_q, remaining_d;
  logic [15:0] move_count_q;

  // Wall-following decision shared by FOLLOW and by REMOVE once the trash is gone.
  state_t      fol_state;
  logic        fol_front, fol_turn, fol_remove;
  logic        fol_right;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fol_state  = FOLLOW;
    fol_front  = 1'b0;
    fol_turn   = 1'b0;
    fol_remove = 1'b0;
    fol_right  = 1'b0;
    if (nav.under) begin
      fol_state = DONE;
    end else if (nav.barrier) begin
      fol_state  = REMOVE;
      fol_remove = 1'b1;
    end else if (!nav.left) begin
      fol_state = ADVANCE;
      fol_turn  = 1'b1;
    end else if (!nav.head) begin
      fol_front = 1'b1;
    end else begin
      fol_state = RIGHT_TURN;
      fol_turn  = 1'b1;
      fol_right = 1'b1;
    end
  end

`ifdef NAV_STUCK_DETECT_EN
  logic [3:0] stuck_cnt_q, stuck_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    front_d     = 1'b0;
    turn_d      = 1'b0;
    remove_d    = 1'b0;
    remaining_d = remaining_q;
    case (state_q)
      FOLLOW: begin
        state_d  = fol_state;
        front_d  = fol_front;
        turn_d   = fol_turn;
        remove_d = fol_remove;
        if (fol_right) remaining_d = 2'd2;
      end
      ADVANCE: begin
        if (nav.under) begin
          state_d = DONE;
        end else if (nav.barrier) begin
          state_d  = REMOVE;
          remove_d = 1'b1;
        end else begin
          state_d = FOLLOW;
          front_d = !nav.head;
        end
      end
      RIGHT_TURN: begin
        turn_d      = 1'b1;
        remaining_d = remaining_q - 2'd1;
        state_d     = (remaining_q <= 2'd1) ? FOLLOW : RIGHT_TURN;
      end
      REMOVE: begin
        if (!nav.under && nav.barrier) begin
          remove_d = 1'b1;
        end else begin
          // With barrier low the shared decision never takes its barrier branch.
          state_d  = fol_state;
          front_d  = fol_front;
          turn_d   = fol_turn;
          remove_d = fol_remove;
          if (fol_right) remaining_d = 2'd2;
        end
      end
      DONE, STUCK: state_d = state_q;
      default:     state_d = FOLLOW;
    endcase

`ifdef NAV_STUCK_DETECT_EN
    stuck_cnt_d = stuck_cnt_q;
    if (turn_d && stuck_cnt_q == 4'd11) begin
      state_d = STUCK;
      turn_d  = 1'b0;
    end else if (front_d || remove_d) begin
      stuck_cnt_d = 4'd0;
    end else if (turn_d) begin
      stuck_cnt_d = stuck_cnt_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q      <= FOLLOW;
      front_q      <= 1'b0;
      turn_q       <= 1'b0;
      remove_q     <= 1'b0;
      remaining_q  <= 2'd0;
      move_count_q <= 16'd0;
`ifdef NAV_STUCK_DETECT_EN
      stuck_cnt_q  <= 4'd0;
`endif
    end else if (nav.step) begin
      state_q     <= state_d;
      front_q     <= front_d;
      turn_q      <= turn_d;
      remove_q    <= remove_d;
      remaining_q <= remaining_d;
      if (front_d && move_count_q != 16'hFFFF) move_count_q <= move_count_q + 16'd1;
`ifdef NAV_STUCK_DETECT_EN
      stuck_cnt_q <= stuck_cnt_d;
`endif
    end
  end

  assign nav.front      = front_q;
  assign nav.turn       = turn_q;
  assign nav.remove     = remove_q;
  assign nav.state      = state_q;
  assign nav.done       = (state_q == DONE);
  assign nav.move_count = move_count_q;
`ifdef NAV_STUCK_DETECT_EN
  assign nav.stuck      = (state_q == STUCK);
`else
  assign nav.stuck      = 1'b0;
`endif

endmodule

// File: tb/tb_robot_navigator.sv
// Table-driven bench for robot_navigator with a queue scoreboard of expected decisions.
// Expected values are written by hand from the navigation rules.
module tb_robot_navigator;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  robot_navigator_if nav ();

  robot_navigator dut (
    .clock (clock),
    .reset (reset),
    .nav   (nav.slave)
  );

  typedef struct packed {
    logic        front;
    logic        turn;
    logic        remove;
    logic [2:0]  state;
    logic        done;
    logic        stuck;
    logic [15:0] mc;
  } exp_t;

  typedef struct {
    logic rst;
    logic stp;
    logic head;
    logic left;
    logic under;
    logic barrier;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t e(logic f, logic t, logic r, logic [2:0] s, logic [15:0] mc);
    exp_t x;
    x.front = f; x.turn = t; x.remove = r; x.state = s;
    x.done = (s == 3'd4); x.stuck = (s == 3'd5); x.mc = mc;
    return x;
  endfunction

  function automatic void add(logic rst, logic stp, logic h, logic l, logic u, logic b, exp_t x);
    vec_t v;
    v.rst = rst; v.stp = stp; v.head = h; v.left = l; v.under = u; v.barrier = b; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got f=%b t=%b r=%b st=%0d done=%b stuck=%b mc=%0d, want f=%b t=%b r=%b st=%0d done=%b stuck=%b mc=%0d",
                  name, got.front, got.turn, got.remove, got.state, got.done, got.stuck, got.mc,
                  want.front, want.turn, want.remove, want.state, want.done, want.stuck, want.mc);
  endtask

  task automatic apply(input string name, input vec_t v);
    exp_t got, want;
    @(negedge clock);
    reset       = v.rst;
    nav.step    = v.stp;
    nav.head    = v.head;
    nav.left    = v.left;
    nav.under   = v.under;
    nav.barrier = v.barrier;
    sb.push_back(v.exp);
    @(posedge clock);
    #1;
    got  = {nav.front, nav.turn, nav.remove, nav.state, nav.done, nav.stuck, nav.move_count};
    want = sb.pop_front();
    check(name, got, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    reset = 1'b1; nav.step = 1'b0; nav.head = 1'b0; nav.left = 1'b1; nav.under = 1'b0; nav.barrier = 1'b0;

    //   rst stp h  l  u  b     f  t  r  st   mc
    add(1, 1, 0, 1, 0, 0, e(0, 0, 0, 0, 0));   // reset with step ignored
    add(0, 1, 0, 1, 0, 0, e(1, 0, 0, 0, 1));   // straight ahead
    add(0, 0, 1, 0, 1, 1, e(1, 0, 0, 0, 1));   // no step: hold
    add(0, 1, 1, 0, 0, 0, e(0, 1, 0, 1, 1));   // opening left
    add(0, 1, 0, 1, 0, 0, e(1, 0, 0, 0, 2));   // advance into it
    add(0, 1, 1, 1, 0, 0, e(0, 1, 0, 2, 2));   // dead end: right turn
    add(0, 1, 1, 1, 1, 1, e(0, 1, 0, 2, 2));   // sensors ignored
    add(0, 1, 0, 0, 1, 1, e(0, 1, 0, 0, 2));   // third turn, back to follow
    add(0, 1, 1, 1, 0, 1, e(0, 0, 1, 3, 2));   // trash
    add(0, 1, 1, 1, 0, 1, e(0, 0, 1, 3, 2));
    add(0, 1, 1, 1, 0, 1, e(0, 0, 1, 3, 2));
    add(0, 1, 0, 1, 0, 0, e(1, 0, 0, 0, 3));   // cleared, follow same step
    add(0, 1, 1, 0, 0, 0, e(0, 1, 0, 1, 3));
    add(0, 1, 1, 1, 0, 0, e(0, 0, 0, 0, 3));   // advance blocked: no command
    add(0, 1, 1, 1, 0, 1, e(0, 0, 1, 3, 3));
    add(0, 1, 1, 0, 0, 0, e(0, 1, 0, 1, 3));   // remove -> follow left turn
    add(0, 1, 0, 1, 0, 1, e(0, 0, 1, 3, 3));   // advance sees trash
    add(0, 1, 0, 1, 1, 1, e(0, 0, 0, 4, 3));   // goal beats trash
    add(0, 1, 0, 1, 0, 0, e(0, 0, 0, 4, 3));   // terminal
    add(0, 1, 0, 0, 0, 1, e(0, 0, 0, 4, 3));
    add(1, 0, 0, 1, 0, 0, e(0, 0, 0, 0, 0));   // reset clears done
    add(0, 1, 1, 1, 0, 0, e(0, 1, 0, 2, 0));
    add(1, 0, 1, 1, 0, 0, e(0, 0, 0, 0, 0));   // reset mid right turn
    add(0, 1, 0, 1, 0, 0, e(1, 0, 0, 0, 1));   // sequence abandoned
    add(0, 1, 1, 1, 0, 1, e(0, 0, 1, 3, 1));
    add(1, 1, 0, 1, 1, 0, e(0, 0, 0, 0, 0));   // reset mid remove, step ignored
    add(0, 1, 1, 1, 1, 0, e(0, 0, 0, 4, 0));   // goal from follow
    add(1, 0, 0, 1, 0, 0, e(0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Boxed in: walls ahead and left for many consecutive steps.
    for (int k = 1; k <= 15; k++) begin
      v.rst = 0; v.stp = 1; v.head = 1; v.left = 1; v.under = 0; v.barrier = 0;
`ifdef NAV_STUCK_DETECT_EN
      if (k < 12) v.exp = e(0, 1, 0, (k % 3 == 0) ? 3'd0 : 3'd2, 0);
      else        v.exp = e(0, 0, 0, 3'd5, 0);
`else
      v.exp = e(0, 1, 0, (k % 3 == 0) ? 3'd0 : 3'd2, 0);
`endif
      apply($sformatf("boxed%0d", k), v);
    end

    // Progress after recovery: a front must follow, counter restarts from reset.
    v.rst = 1; v.stp = 0; v.head = 0; v.left = 1; v.under = 0; v.barrier = 0;
    v.exp = e(0, 0, 0, 0, 0);
    apply("boxed_reset", v);
    v.rst = 0; v.stp = 1;
    v.exp = e(1, 0, 0, 0, 1);
    apply("boxed_recover", v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
